// File: rtl/s10_mem_packet_writer.sv
// Packet-buffer write front end: stores a sop/eop word stream into a RAM write port and publishes a commit pointer.
// Latency: RAM write 1 cycle after the accepted beat; commit_pointer/packet_committed 2 cycles after the eop beat.
// Backpressure: in_ready drops while the buffer is full (except while discarding an oversize packet); it never depends on in_valid.
module s10_mem_packet_writer #(
    parameter int CAPACITY      = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = $clog2(CAPACITY)
) (
    input  logic                     write_clk,
    input  logic                     write_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic                     in_error,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH:0]   read_done_pointer,
    output logic [ADDRESS_WIDTH:0]   commit_pointer,
    output logic                     packet_committed,
    output logic                     packet_dropped,
    output logic                     packet_oversize
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH:0] CAP_PTR = (ADDRESS_WIDTH + 1)'(CAPACITY);

    state_t                   state;
    logic [ADDRESS_WIDTH:0]   spec_ptr;      // speculative pointer: next free slot of the packet being written
    logic [ADDRESS_WIDTH:0]   pend_ptr;      // commit value waiting for the RAM to capture the eop word
    logic                     pend_vld;

    logic [ADDRESS_WIDTH:0]   commit_eff;    // commit pointer including a commit still in flight
    logic [ADDRESS_WIDTH:0]   occupancy;
    logic                     full;
    logic                     beat;
    logic                     store;
    logic                     restart;
    logic                     oversize;
    logic [ADDRESS_WIDTH:0]   store_ptr;
    logic [ADDRESS_WIDTH:0]   after_ptr;

    // Rewinds must land on the newest commit, even one that has not reached commit_pointer yet.
    assign commit_eff = pend_vld ? pend_ptr : commit_pointer;

    // Wrap-bit arithmetic: the subtraction wraps modulo 2^(ADDRESS_WIDTH+1), so full and empty stay distinct.
    assign occupancy = spec_ptr - read_done_pointer;
    assign full      = (occupancy == CAP_PTR);

    // Discarding beats never consumes space, so DROP keeps accepting even if the pointers look full.
    assign in_ready  = !write_reset && ((state == DROP) || !full);
    assign beat      = in_valid && in_ready;

    // A packet that alone fills the whole buffer can never complete; give up on it.
    assign oversize  = (state == WRITE) && full && (commit_eff == read_done_pointer);

    // Words are stored when they open a packet or continue one; stray beats outside a packet are ignored.
    assign store     = beat && (in_sop || (state == WRITE));
    assign restart   = beat && in_sop && (state == WRITE);

    // A sop always starts at the committed boundary, which also rewinds an interrupted packet.
    assign store_ptr = in_sop ? commit_eff : spec_ptr;
    assign after_ptr = store_ptr + 1'b1;

    // Packet FSM plus all registered outputs: RAM write port, pointers and status pulses.
    always_ff @(posedge write_clk) begin
        if (write_reset) begin
            state            <= IDLE;
            spec_ptr         <= '0;
            pend_ptr         <= '0;
            pend_vld         <= 1'b0;
            commit_pointer   <= '0;
            write_enable     <= 1'b0;
            write_pointer    <= '0;
            write_data       <= '0;
            packet_committed <= 1'b0;
            packet_dropped   <= 1'b0;
            packet_oversize  <= 1'b0;
        end else begin
            write_enable     <= 1'b0;
            packet_dropped   <= 1'b0;
            packet_oversize  <= 1'b0;

            // Second stage of a commit: publish it on the edge the RAM takes the eop word.
            packet_committed <= pend_vld;
            pend_vld         <= 1'b0;
            if (pend_vld) begin
                commit_pointer <= pend_ptr;
            end

            if (oversize) begin
                spec_ptr        <= commit_eff;
                packet_oversize <= 1'b1;
                state           <= DROP;
            end else if (store) begin
                write_enable  <= 1'b1;
                write_pointer <= store_ptr[ADDRESS_WIDTH-1:0];
                write_data    <= in_data;
                if (restart) begin
                    packet_dropped <= 1'b1;
                end
                if (in_eop) begin
                    state <= IDLE;
                    if (in_error) begin
                        // Bad packet: its words stay in RAM but are invisible and get overwritten.
                        spec_ptr       <= commit_eff;
                        packet_dropped <= 1'b1;
                    end else begin
                        spec_ptr <= after_ptr;
                        pend_ptr <= after_ptr;
                        pend_vld <= 1'b1;
                    end
                end else begin
                    spec_ptr <= after_ptr;
                    state    <= WRITE;
                end
            end else if (beat && in_eop && (state == DROP)) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_s10_mem_packet_writer.sv
// Bench for s10_mem_packet_writer: packet-level reference model checked every cycle, plus directed scenarios.
// Latency expectations: write 1 cycle after a beat, commit 2 cycles after an eop beat.
// Stimulus holds in_valid until the DUT's in_ready accepts the beat (bounded wait).
module tb_s10_mem_packet_writer;

    localparam int CAP = 16;
    localparam int PM  = 2 * CAP;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic        in_error;
    logic        write_enable;
    logic [3:0]  write_pointer;
    logic [31:0] write_data;
    logic [4:0]  read_done_pointer;
    logic [4:0]  commit_pointer;
    logic        packet_committed;
    logic        packet_dropped;
    logic        packet_oversize;

    always #5 clk = ~clk;

    s10_mem_packet_writer #(.CAPACITY(16), .DATA_WIDTH(32), .ADDRESS_WIDTH(4)) dut (
        .write_clk         (clk),
        .write_reset       (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_sop            (in_sop),
        .in_eop            (in_eop),
        .in_error          (in_error),
        .write_enable      (write_enable),
        .write_pointer     (write_pointer),
        .write_data        (write_data),
        .read_done_pointer (read_done_pointer),
        .commit_pointer    (commit_pointer),
        .packet_committed  (packet_committed),
        .packet_dropped    (packet_dropped),
        .packet_oversize   (packet_oversize)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: packet = committed base + number of words stored so far.
    // mode 0 = between packets, 1 = inside a packet, 2 = discarding an oversize packet.
    int m_base, m_len, m_mode, m_pend, m_pend_val;
    int e_commit, e_committed, e_we, e_wp, e_wd, e_drop, e_over;
    bit cmp_on = 1'b0;

    function automatic int model_occ();
        return (m_base + m_len - int'(read_done_pointer)) & (PM - 1);
    endfunction

    function automatic int model_ready();
        return (!rst && (m_mode == 2 || model_occ() != CAP)) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int rdy;
        int occ;
        rdy = model_ready();
        occ = model_occ();
        if (rst) begin
            m_base = 0; m_len = 0; m_mode = 0; m_pend = 0; m_pend_val = 0;
            e_commit = 0; e_committed = 0; e_we = 0; e_wp = 0; e_wd = 0; e_drop = 0; e_over = 0;
            cmp_on = 1'b1;
        end else begin
            e_we = 0; e_drop = 0; e_over = 0;
            e_committed = m_pend;
            if (m_pend != 0) e_commit = m_pend_val;
            m_pend = 0;
            if (m_mode == 1 && occ == CAP && m_base == int'(read_done_pointer)) begin
                m_len = 0; m_mode = 2; e_over = 1;
            end else if (in_valid && rdy != 0) begin
                if (in_sop || m_mode == 1) begin
                    if (in_sop) begin
                        if (m_mode == 1) e_drop = 1;
                        m_len = 0;
                    end
                    e_we = 1;
                    e_wp = (m_base + m_len) % CAP;
                    e_wd = int'(in_data);
                    m_len++;
                    if (in_eop) begin
                        if (in_error) begin
                            e_drop = 1;
                        end else begin
                            m_base = (m_base + m_len) % PM;
                            m_pend = 1;
                            m_pend_val = m_base;
                        end
                        m_len = 0; m_mode = 0;
                    end else begin
                        m_mode = 1;
                    end
                end else if (in_eop && m_mode == 2) begin
                    m_mode = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("in_ready", 32'(in_ready), model_ready());
            check("write_enable", 32'(write_enable), e_we);
            if (e_we != 0) begin
                check("write_pointer", 32'(write_pointer), e_wp);
                check("write_data", write_data, e_wd);
            end
            check("commit_pointer", 32'(commit_pointer), e_commit);
            check("packet_committed", 32'(packet_committed), e_committed);
            check("packet_dropped", 32'(packet_dropped), e_drop);
            check("packet_oversize", 32'(packet_oversize), e_over);
        end
    end

    // Event log used by the directed checks (snapshot-and-difference, never reset).
    int wr_cnt = 0, drop_cnt = 0, over_cnt = 0;
    int wlog [0:1023];
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wlog[wr_cnt & 1023] = int'(write_pointer);
            wr_cnt++;
        end
        if (packet_dropped === 1'b1) drop_cnt++;
        if (packet_oversize === 1'b1) over_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int d, input bit s, input bit e, input bit err);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_error = err;
        while (!done && t < 200) begin
            @(negedge clk);
            done = (in_ready === 1'b1);
            t++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles, expected acceptance", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    endtask

    task automatic send_pkt(input int base, input int n, input bit err);
        for (int i = 0; i < n; i++) begin
            beat(base + i, i == 0, i == n - 1, err && (i == n - 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr, s_drop, s_over;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
        read_done_pointer = '0;
        idle(3);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_write_enable", 32'(write_enable), 0);
        check("reset_write_pointer", 32'(write_pointer), 0);
        check("reset_write_data", write_data, 0);
        check("reset_commit", 32'(commit_pointer), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 1: 4-word packet -> addresses 0..3; commit lands two edges after the eop beat.
        s_wr = wr_cnt;
        send_pkt(32'h100, 4, 1'b0);
        @(negedge clk);
        check("t1_commit_after_1_edge", 32'(commit_pointer), 0);
        @(negedge clk);
        check("t1_commit_after_2_edges", 32'(commit_pointer), 4);
        check("t1_committed_pulse", 32'(packet_committed), 1);
        idle(1);
        check("t1_writes", wr_cnt - s_wr, 4);
        check("t1_first_addr", wlog[s_wr & 1023], 0);

        // 2: errored packet writes 4..6, is dropped, next packet restarts at 4.
        s_wr = wr_cnt; s_drop = drop_cnt;
        send_pkt(32'h200, 3, 1'b1);
        idle(3);
        check("t2_writes", wr_cnt - s_wr, 3);
        check("t2_drop_pulses", drop_cnt - s_drop, 1);
        check("t2_commit_held", 32'(commit_pointer), 4);
        s_wr = wr_cnt;
        send_pkt(32'h300, 8, 1'b0);
        idle(3);
        check("t2_next_first_addr", wlog[s_wr & 1023], 4);
        check("t2_commit", 32'(commit_pointer), 12);

        // 3: commit=12, read_done=0: stall after 4 words until the reader frees 2 slots.
        for (int i = 0; i < 4; i++) beat(32'h400 + i, i == 0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'h404; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_stalled", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        read_done_pointer = 5'd2;
        beat(32'h404, 1'b0, 1'b0, 1'b0);
        beat(32'h405, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t3_commit_wrapped", 32'(commit_pointer), 18);

        // 4: empty buffer, 20-word packet -> 16 writes, oversize, tail discarded.
        read_done_pointer = 5'd18;
        s_wr = wr_cnt; s_over = over_cnt;
        send_pkt(32'h500, 20, 1'b0);
        idle(3);
        check("t4_writes", wr_cnt - s_wr, 16);
        check("t4_oversize_pulses", over_cnt - s_over, 1);
        check("t4_commit_held", 32'(commit_pointer), 18);
        s_wr = wr_cnt;
        send_pkt(32'h600, 2, 1'b0);
        idle(3);
        check("t4_next_first_addr", wlog[s_wr & 1023], 2);
        check("t4_next_commit", 32'(commit_pointer), 20);

        // 4b: oversize again, then a single sop+eop beat while discarding is stored and committed.
        read_done_pointer = 5'd20;
        s_wr = wr_cnt; s_over = over_cnt;
        for (int i = 0; i < 17; i++) beat(32'h700 + i, i == 0, 1'b0, 1'b0);
        beat(32'h7ff, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("t4b_writes", wr_cnt - s_wr, 17);
        check("t4b_oversize_pulses", over_cnt - s_over, 1);
        check("t4b_single_addr", wlog[(s_wr + 16) & 1023], 4);
        check("t4b_commit", 32'(commit_pointer), 21);

        // 5: sop interrupts a packet after 2 words; new packet restarts at commit (addr 5).
        s_drop = drop_cnt;
        beat(32'h800, 1'b1, 1'b0, 1'b0);
        beat(32'h801, 1'b0, 1'b0, 1'b0);
        idle(1);
        s_wr = wr_cnt;
        beat(32'h900, 1'b1, 1'b0, 1'b0);
        beat(32'h901, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t5_drop_pulses", drop_cnt - s_drop, 1);
        check("t5_restart_addr", wlog[s_wr & 1023], 5);
        check("t5_commit", 32'(commit_pointer), 23);
        s_wr = wr_cnt;
        beat(32'ha00, 1'b0, 1'b0, 1'b0);
        beat(32'ha01, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("t5_stray_writes", wr_cnt - s_wr, 0);

        // 6: reset mid-packet, then the first packet writes from 0.
        beat(32'hb00, 1'b1, 1'b0, 1'b0);
        beat(32'hb01, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        read_done_pointer = '0;
        @(negedge clk);
        check("t6_ready_in_reset", 32'(in_ready), 0);
        @(negedge clk);
        check("t6_write_enable", 32'(write_enable), 0);
        check("t6_write_pointer", 32'(write_pointer), 0);
        check("t6_commit", 32'(commit_pointer), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        s_wr = wr_cnt;
        send_pkt(32'hc00, 2, 1'b0);
        idle(3);
        check("t6_first_addr", wlog[s_wr & 1023], 0);
        check("t6_commit_after", 32'(commit_pointer), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
